// File: rtl/timer_pkg.sv
// Shared types and constants for the 8-bit timer counter engine.
package timer_pkg;

   typedef enum logic [1:0] {
      ONE_SHOT = 2'd0,
      PERIODIC = 2'd1,
      UPDOWN   = 2'd2,
      PWM      = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN_UP   = 3'd1,
      RUN_DOWN = 3'd2,
      DONE     = 3'd3,
      HOLD     = 3'd4
   } state_e;

   localparam int INT_OVF = 0;
   localparam int INT_M0  = 1;
   localparam int INT_M1  = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider: tick every cycle when disabled, else once per PRESCALE cycles.
module timer_prescaler #(
   parameter int PRESCALE = 8
) (
   input  logic clk,
   input  logic rst_b,
   input  logic clear_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic          wrap;

   assign wrap = (pre_q == LAST);

   always_comb begin
      pre_d = pre_q;
      if (clear_i)
         pre_d = '0;
      else if (en_i)
         pre_d = wrap ? '0 : pre_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)
         pre_q <= '0;
      else
         pre_q <= pre_d;
   end

   assign tick_o = en_i ? wrap : 1'b1;

endmodule

// File: rtl/timer_cnt_ctrl.sv
// Timer counter sequencing: prescaled ticks drive an up / up-down counter,
// raising sticky overflow/match flags and waveform outputs.
module timer_cnt_ctrl
   import timer_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int PRESCALE = 8
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic [2:0]       operation_mode,
   input  logic             clock_select,
   input  logic [CNT_W-1:0] cnt_max,
   input  logic [CNT_W-1:0] match0,
   input  logic [CNT_W-1:0] match1,
   input  logic             overflow_int_en,
   input  logic             match0_int_en,
   input  logic             match1_int_en,
   input  logic [2:0]       int_clr,
   output logic [CNT_W-1:0] count,
   output logic [2:0]       int_status,
   output logic             out0,
   output logic             out1,
   output logic             irq
);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [2:0]       flags_q, flags_d;
   logic [1:0]       out_q, out_d;
   logic [2:0]       set;
   logic [1:0]       hit;
   logic             tick, top;

   timer_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .clk     (clk),
      .rst_b   (rst_b),
      .clear_i ((state_q == IDLE) || !start),
      .en_i    (clock_select),
      .tick_o  (tick)
   );

   // >= rather than == so a lowered cnt_max wraps on the next tick
   assign top = (count_q >= cnt_max);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!start) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:     state_d = operation_mode[2] ? HOLD : RUN_UP;
            RUN_UP: begin
               if (tick && top) begin
                  if (mode_q == ONE_SHOT)
                     state_d = DONE;
                  else if (mode_q == UPDOWN)
                     state_d = RUN_DOWN;
               end
            end
            RUN_DOWN: if (tick && (count_q == '0)) state_d = RUN_UP;
            default:  state_d = state_q;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      mode_d  = mode_q;
      out_d   = out_q;
      set     = 3'b000;
      hit     = 2'b00;
      if (!start || (state_q == IDLE)) begin
         count_d = '0;
         out_d   = 2'b00;
         if (start)
            mode_d = mode_e'(operation_mode[1:0]);
      end else if (tick && ((state_q == RUN_UP) || (state_q == RUN_DOWN))) begin
         if (state_q == RUN_UP) begin
            if (top) begin
               case (mode_q)
                  ONE_SHOT: begin
                     count_d      = cnt_max;
                     set[INT_OVF] = 1'b1;
                  end
                  UPDOWN:   count_d = (cnt_max == '0) ? '0 : count_q - 1'b1;
                  default: begin
                     count_d      = '0;
                     set[INT_OVF] = 1'b1;
                  end
               endcase
            end else begin
               count_d = count_q + 1'b1;
            end
         end else if (count_q == '0) begin
            set[INT_OVF] = 1'b1;
            count_d      = (cnt_max == '0) ? '0 : CNT_W'(1);
         end else begin
            count_d = count_q - 1'b1;
         end
         hit[0]      = (count_d == match0);
         hit[1]      = (count_d == match1);
         set[INT_M0] = hit[0];
         set[INT_M1] = hit[1];
         if (mode_q == PWM)
            out_d = {(count_d < match1), (count_d < match0)};
         else
            out_d = out_q ^ hit;
      end
      // a set in the same cycle as a clear wins
      flags_d = (flags_q & ~int_clr) | set;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         mode_q  <= ONE_SHOT;
         count_q <= '0;
         flags_q <= 3'b000;
         out_q   <= 2'b00;
      end else begin
         mode_q  <= mode_d;
         count_q <= count_d;
         flags_q <= flags_d;
         out_q   <= out_d;
      end
   end

   assign count      = count_q;
   assign int_status = flags_q;
   assign out0       = out_q[0];
   assign out1       = out_q[1];
   assign irq        = |(flags_q & {match1_int_en, match0_int_en, overflow_int_en});

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Bench for timer_cnt_ctrl: directed scenarios plus randomized runs against a behavioural model.
module tb_timer_cnt_ctrl;

   localparam int CNT_W    = 8;
   localparam int PRESCALE = 8;

   logic             clk = 1'b0;
   logic             rst_b;
   logic             start;
   logic [2:0]       operation_mode;
   logic             clock_select;
   logic [CNT_W-1:0] cnt_max, match0, match1;
   logic             overflow_int_en, match0_int_en, match1_int_en;
   logic [2:0]       int_clr;
   logic [CNT_W-1:0] count;
   logic [2:0]       int_status;
   logic             out0, out1, irq;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit       m_started, m_counting;
   int       m_mode, m_cnt, m_pre, m_dir;
   bit [2:0] m_flags;
   bit       m_out0, m_out1;

   timer_cnt_ctrl #(.CNT_W(CNT_W), .PRESCALE(PRESCALE)) dut (
      .clk             (clk),
      .rst_b           (rst_b),
      .start           (start),
      .operation_mode  (operation_mode),
      .clock_select    (clock_select),
      .cnt_max         (cnt_max),
      .match0          (match0),
      .match1          (match1),
      .overflow_int_en (overflow_int_en),
      .match0_int_en   (match0_int_en),
      .match1_int_en   (match1_int_en),
      .int_clr         (int_clr),
      .count           (count),
      .int_status      (int_status),
      .out0            (out0),
      .out1            (out1),
      .irq             (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_started  = 0;
      m_counting = 0;
      m_mode     = 0;
      m_cnt      = 0;
      m_pre      = 0;
      m_dir      = 1;
      m_flags    = 3'b000;
      m_out0     = 0;
      m_out1     = 0;
   endtask

   // One clock edge of the timer, from the rules: stop clears, start launches,
   // each tick moves the count one step up or down and bounces/wraps at the limits.
   task automatic model_update();
      bit [2:0] set;
      int       nxt;
      bit       tk;
      set = 3'b000;
      if (!start) begin
         m_started  = 0;
         m_counting = 0;
         m_cnt      = 0;
         m_pre      = 0;
         m_out0     = 0;
         m_out1     = 0;
      end else if (!m_started) begin
         m_started  = 1;
         m_mode     = int'(operation_mode);
         m_counting = (m_mode < 4);
         m_pre      = 0;
         m_dir      = 1;
      end else if (m_counting) begin
         tk = (clock_select == 1'b0) || (m_pre == PRESCALE - 1);
         if (clock_select)
            m_pre = (m_pre == PRESCALE - 1) ? 0 : m_pre + 1;
         if (tk) begin
            if (m_dir > 0 && m_cnt >= int'(cnt_max)) begin
               if (m_mode == 0) begin
                  nxt        = int'(cnt_max);
                  set[0]     = 1;
                  m_counting = 0;
               end else if (m_mode == 2) begin
                  nxt   = (cnt_max == 0) ? 0 : m_cnt - 1;
                  m_dir = -1;
               end else begin
                  nxt    = 0;
                  set[0] = 1;
               end
            end else if (m_dir > 0) begin
               nxt = m_cnt + 1;
            end else if (m_cnt == 0) begin
               set[0] = 1;
               nxt    = (cnt_max == 0) ? 0 : 1;
               m_dir  = 1;
            end else begin
               nxt = m_cnt - 1;
            end
            set[1] = (nxt == int'(match0));
            set[2] = (nxt == int'(match1));
            if (m_mode == 3) begin
               m_out0 = (nxt < int'(match0));
               m_out1 = (nxt < int'(match1));
            end else begin
               m_out0 = m_out0 ^ set[1];
               m_out1 = m_out1 ^ set[2];
            end
            m_cnt = nxt;
         end
      end
      m_flags = (m_flags & ~int_clr) | set;
   endtask

   task automatic check_all();
      check("count", count, m_cnt);
      check("int_status", int_status, m_flags);
      check("out0", out0, m_out0);
      check("out1", out1, m_out1);
      check("irq", irq, |(m_flags & {match1_int_en, match0_int_en, overflow_int_en}));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int seq1[5];
      int seq2[6];
      int hi0, hi1;
      seq1 = '{1, 2, 3, 0, 1};
      seq2 = '{1, 2, 1, 0, 1, 2};

      rst_b = 1'b1;
      start = 1'b0;
      operation_mode = 3'd0;
      clock_select = 1'b0;
      cnt_max = 8'd0;
      match0 = 8'd200;
      match1 = 8'd200;
      overflow_int_en = 1'b0;
      match0_int_en = 1'b0;
      match1_int_en = 1'b0;
      int_clr = 3'b000;
      model_reset();
      #1 rst_b = 1'b0;
      #2;
      check("rst_count", count, 0);
      check("rst_status", int_status, 0);
      check("rst_out0", out0, 0);
      check("rst_out1", out1, 0);
      check("rst_irq", irq, 0);
      @(negedge clk);
      rst_b = 1'b1;

      // periodic, cnt_max=3, overflow interrupt initially disabled
      operation_mode = 3'd1;
      cnt_max = 8'd3;
      start = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         check("m1_seq", count, seq1[i]);
      end
      check("m1_ovf_flag", int_status[0], 1);
      check("m1_irq_disabled", irq, 0);
      overflow_int_en = 1'b1;
      #1 check("m1_irq_enabled", irq, 1);

      // clear racing with a new overflow
      start = 1'b0;
      int_clr = 3'b111;
      step();
      int_clr = 3'b000;
      start = 1'b1;
      step();
      repeat (3) step();
      check("clr_pre_count", count, 3);
      int_clr = 3'b001;
      step();
      check("clr_race_flag", int_status[0], 1);
      step();
      check("clr_alone_flag", int_status[0], 0);
      check("clr_alone_irq", irq, 0);
      int_clr = 3'b000;

      // one-shot through the prescaler
      start = 1'b0;
      int_clr = 3'b111;
      step();
      int_clr = 3'b000;
      operation_mode = 3'd0;
      cnt_max = 8'd5;
      clock_select = 1'b1;
      start = 1'b1;
      step();
      repeat (7) step();
      check("m0_before_tick", count, 0);
      step();
      check("m0_first_tick", count, 1);
      repeat (50) step();
      check("m0_done_count", count, 5);
      check("m0_ovf_once", int_status[0], 1);
      start = 1'b0;
      step();
      check("m0_stop_clear", count, 0);

      // up-down, cnt_max=2, match0 at the peak
      int_clr = 3'b111;
      step();
      int_clr = 3'b000;
      operation_mode = 3'd2;
      cnt_max = 8'd2;
      match0 = 8'd2;
      clock_select = 1'b0;
      start = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         step();
         check("m2_seq", count, seq2[i]);
         if (i == 1) check("m2_out0_peak1", out0, 1);
         if (i == 5) check("m2_out0_peak2", out0, 0);
      end
      check("m2_m0_flag", int_status[1], 1);

      // PWM, cnt_max=9, match0=4 gives 40% duty, match1=0 keeps out1 low
      start = 1'b0;
      step();
      operation_mode = 3'd3;
      cnt_max = 8'd9;
      match0 = 8'd4;
      match1 = 8'd0;
      start = 1'b1;
      step();
      hi0 = 0;
      hi1 = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         hi0 += int'(out0);
         hi1 += int'(out1);
      end
      check("pwm_out0_duty", hi0, 4);
      check("pwm_out1_low", hi1, 0);

      // reserved mode holds at zero
      start = 1'b0;
      int_clr = 3'b111;
      step();
      int_clr = 3'b000;
      operation_mode = 3'd5;
      match0 = 8'd0;
      start = 1'b1;
      repeat (20) step();
      check("hold_count", count, 0);
      check("hold_flags", int_status, 0);

      // asynchronous reset in the middle of a run
      start = 1'b0;
      step();
      operation_mode = 3'd1;
      cnt_max = 8'd7;
      match0 = 8'd3;
      start = 1'b1;
      repeat (6) step();
      #2 rst_b = 1'b0;
      #1;
      check("arst_count", count, 0);
      check("arst_status", int_status, 0);
      check("arst_out0", out0, 0);
      check("arst_irq", irq, 0);
      model_reset();
      @(negedge clk);
      rst_b = 1'b1;

      // randomized runs
      for (int seg = 0; seg < 25; seg++) begin
         start = 1'b0;
         step();
         operation_mode = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         clock_select = ($urandom_range(0, 3) == 0);
         cnt_max = 8'($urandom_range(0, 12));
         match0 = 8'($urandom_range(0, 13));
         match1 = 8'($urandom_range(0, 13));
         overflow_int_en = 1'($urandom);
         match0_int_en = 1'($urandom);
         match1_int_en = 1'($urandom);
         start = 1'b1;
         repeat ($urandom_range(15, 60)) begin
            int_clr = ($urandom_range(0, 6) == 0) ? 3'($urandom) : 3'b000;
            if ($urandom_range(0, 29) == 0) cnt_max = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) operation_mode = 3'($urandom);
            if ($urandom_range(0, 39) == 0) clock_select = ~clock_select;
            if ($urandom_range(0, 9) == 0) overflow_int_en = ~overflow_int_en;
            start = ($urandom_range(0, 49) != 0);
            step();
         end
         int_clr = 3'b000;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_cnt_ctrl.md
# timer_cnt_ctrl

Counter sequencing engine for the 8-bit timer peripheral. Takes the static configuration decoded by the timer register file (start, operation mode, clock select, max value, match values, interrupt enables), runs the prescaler and counter state machine, detects overflow/match events, keeps sticky interrupt status, and drives the waveform outputs and the interrupt line. It sits between the register file and the timer pins/interrupt controller.

## Interface
- CNT_W, 8, counter and compare width
- PRESCALE, 8, divide ratio when clock_select=1 (≥2)
- clk  in  1  module clock
- rst_b  in  1  reset, asynchronous, active-low
- start  in  1  level; 1 = run, 0 = stop and clear
- operation_mode  in  3  0 one-shot up, 1 periodic up, 2 up-down, 3 PWM up; 4-7 reserved
- clock_select  in  1  0 = tick every clk, 1 = tick every PRESCALE clks
- cnt_max  in  CNT_W  terminal count
- match0, match1  in  CNT_W  compare values
- overflow_int_en, match0_int_en, match1_int_en  in  1  interrupt enables
- int_clr  in  3  write-1-to-clear pulse, bit0 ovf, bit1 m0, bit2 m1
- count  out  CNT_W  current counter value
- int_status  out  3  sticky flags, same bit order as int_clr
- out0, out1  out  1  waveform outputs
- irq  out  1  |(int_status & enables)

## Operation
- States: IDLE, RUN_UP, RUN_DOWN, DONE, HOLD.
- IDLE: count=0, prescaler=0. On start=1: mode sampled into mode_q; mode 0-3 → RUN_UP; 4-7 → HOLD.
- start=0 in any state → IDLE next edge, count and prescaler cleared; flags retained.
- Mode changes while not IDLE ignored until restart; cnt_max/match changes take effect immediately.
- tick: clock_select=0 → every cycle; 1 → when prescaler==PRESCALE-1 (prescaler wraps to 0). clock_select sampled live.
- RUN_UP, on tick: if count ≥ cnt_max → event "top"; else count+1.
  - mode 0: top → count holds cnt_max, ovf flag set, → DONE.
  - mode 1, 3: top → count=0, ovf flag set.
  - mode 2: top → count−1 (0 if cnt_max=0), → RUN_DOWN; no ovf.
- RUN_DOWN, on tick: count==0 → ovf set, count+1 (0 if cnt_max=0), → RUN_UP; else count−1.
- DONE: count frozen; only start=0 leaves. HOLD: count frozen at 0, no events.
- Match: on a tick where next count equals matchN, flag N set.
- Flags set regardless of enables; int_clr bit clears; simultaneous set and clear on same bit → set wins.
- out0/out1: modes 0-2 toggle on matchN event; mode 3 out N = (next count < matchN) each tick; cleared to 0 in IDLE.
- cnt_max lowered below count while running → next tick treated as top.

## Timing
- Reset: count=0, int_status=0, out0=out1=0, irq=0, state IDLE, prescaler 0.
- start sampled at edge E → RUN_UP after E; first increment on first tick after E (clock_select=0: count=1 after E+1).
- count, flags, outN all update on the same edge as the tick that causes them.
- irq combinational from registered flags/enables: high in the cycle after the event edge, no extra latency; enable toggle affects irq same cycle.
- int_clr takes effect at next edge.

## Structure
- Package timer_pkg: mode enum (ONE_SHOT, PERIODIC, UPDOWN, PWM), state enum, interrupt bit index constants (INT_OVF=0, INT_M0=1, INT_M1=2).
- Sub-module timer_prescaler (PRESCALE param, clear input, tick output); remainder in timer_cnt_ctrl.

## Test plan
- Mode 1, cnt_max=3, clock_select=0, start=1: count 1,2,3,0,1…; ovf flag set on 3→0 edge; irq high only with overflow_int_en=1.
- Mode 0, cnt_max=5, clock_select=1, PRESCALE=8: count increments every 8 clks, stops at 5 in DONE, ovf set once; start=0 → count 0 next edge.
- Mode 2, cnt_max=2: count 1,2,1,0,1…; ovf only on 0→1; match0=2 sets m0 flag and toggles out0 each peak.
- Mode 3, cnt_max=9, match0=4: out0 high for counts 0-3, low 4-9, 40% duty; match1=0 → out1 constantly low.
- int_clr=3'b001 on same edge as ovf event → flag stays 1; int_clr alone next cycle → flag 0, irq 0.
- operation_mode=5 → HOLD, count stays 0, no flags; rst_b low mid-run → all outputs 0 asynchronously.
